// File: rtl/video_frame_sanitizer.sv
// Frame sanitizer: locks onto SOF, enforces H_ACTIVE x V_ACTIVE geometry, pads/truncates lines and frames.
// Optional statistics counters are enabled by defining VFS_STATS_EN.
module video_frame_sanitizer #(
    parameter int                  D_WIDTH   = 8,
    parameter int                  H_ACTIVE  = 640,
    parameter int                  V_ACTIVE  = 480,
    parameter logic [D_WIDTH-1:0]  PAD_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_tlast,
    input  logic               up_tuser,
    input  logic               up_tvalid,
    output logic               up_tready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_tlast,
    output logic               down_tuser,
    output logic               down_tvalid,
    input  logic               down_tready
`ifdef VFS_STATS_EN
    ,
    output logic [15:0]        stat_frames,
    output logic [15:0]        stat_short_lines,
    output logic [15:0]        stat_long_lines,
    output logic [15:0]        stat_short_frames,
    output logic [15:0]        stat_dropped
`endif
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    localparam logic [2:0] S_WAIT_SOF  = 3'd0;
    localparam logic [2:0] S_PASS      = 3'd1;
    localparam logic [2:0] S_PAD_LINE  = 3'd2;
    localparam logic [2:0] S_DROP_LINE = 3'd3;
    localparam logic [2:0] S_PAD_FRAME = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic [D_WIDTH-1:0] data_q;
    logic               tlast_q, tuser_q, tvalid_q;

    logic               adv;
    logic               last_x, last_y, origin;
    logic               emit;
    logic [D_WIDTH-1:0] emit_data;

    assign adv    = !tvalid_q || down_tready;
    assign last_x = (x_q == X_LAST);
    assign last_y = (y_q == Y_LAST);
    assign origin = (x_q == '0) && (y_q == '0);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        up_tready = 1'b0;
        emit      = 1'b0;
        emit_data = PAD_VALUE;
        case (state_q)
            S_WAIT_SOF: begin
                // An SOF beat is left on the bus so PASS can take it as pixel (0,0).
                up_tready = !up_tuser;
                if (up_tvalid && up_tuser) begin
                    state_d = S_PASS;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_PASS: begin
                up_tready = adv && !(up_tuser && !origin);
                if (up_tvalid && up_tuser && !origin) begin
                    state_d = S_PAD_FRAME;
                end else if (up_tvalid && adv) begin
                    emit      = 1'b1;
                    emit_data = up_data;
                    if (last_x && last_y)
                        state_d = S_WAIT_SOF;
                    else if (last_x && !up_tlast)
                        state_d = S_DROP_LINE;
                    else if (!last_x && up_tlast)
                        state_d = S_PAD_LINE;
                end
            end
            S_PAD_LINE: begin
                if (adv) begin
                    emit = 1'b1;
                    if (last_x)
                        state_d = last_y ? S_WAIT_SOF : S_PASS;
                end
            end
            S_DROP_LINE: begin
                up_tready = !up_tuser;
                if (up_tvalid) begin
                    if (up_tuser)
                        state_d = S_PAD_FRAME;
                    else if (up_tlast)
                        state_d = S_PASS;
                end
            end
            S_PAD_FRAME: begin
                if (adv) begin
                    emit = 1'b1;
                    if (last_x && last_y)
                        state_d = S_PASS;
                end
            end
            default: state_d = S_WAIT_SOF;
        endcase

        if (emit) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT_SOF;
            x_q      <= '0;
            y_q      <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (adv) begin
                tvalid_q <= emit;
                if (emit) begin
                    data_q  <= emit_data;
                    tlast_q <= last_x;
                    tuser_q <= origin;
                end
            end
        end
    end

    assign down_data   = data_q;
    assign down_tlast  = tlast_q;
    assign down_tuser  = tuser_q;
    assign down_tvalid = tvalid_q;

`ifdef VFS_STATS_EN
    logic [15:0] frames_q, short_lines_q, long_lines_q, short_frames_q, dropped_q;
    logic        enter_pad_line, enter_drop_line, enter_pad_frame, dropped_beat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    assign enter_pad_line  = (state_q != S_PAD_LINE)  && (state_d == S_PAD_LINE);
    assign enter_drop_line = (state_q != S_DROP_LINE) && (state_d == S_DROP_LINE);
    assign enter_pad_frame = (state_q != S_PAD_FRAME) && (state_d == S_PAD_FRAME);
    assign dropped_beat    = up_tvalid && up_tready &&
                             ((state_q == S_WAIT_SOF) || (state_q == S_DROP_LINE));

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q       <= '0;
            short_lines_q  <= '0;
            long_lines_q   <= '0;
            short_frames_q <= '0;
            dropped_q      <= '0;
        end else begin
            frames_q       <= sat_inc(frames_q, emit && origin);
            short_lines_q  <= sat_inc(short_lines_q, enter_pad_line);
            long_lines_q   <= sat_inc(long_lines_q, enter_drop_line);
            short_frames_q <= sat_inc(short_frames_q, enter_pad_frame);
            dropped_q      <= sat_inc(dropped_q, dropped_beat);
        end
    end

    assign stat_frames       = frames_q;
    assign stat_short_lines  = short_lines_q;
    assign stat_long_lines   = long_lines_q;
    assign stat_short_frames = short_frames_q;
    assign stat_dropped      = dropped_q;
`endif

endmodule

// File: tb/tb_video_frame_sanitizer.sv
// Self-checking bench for video_frame_sanitizer (H_ACTIVE=4, V_ACTIVE=2, PAD_VALUE=8'hEE).
// Expected output comes from a frame/line level parser of the input beat stream.
module tb_video_frame_sanitizer;

    localparam int          H   = 4;
    localparam int          V   = 2;
    localparam logic [7:0]  PAD = 8'hEE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] up_data = '0;
    logic       up_tlast = 1'b0;
    logic       up_tuser = 1'b0;
    logic       up_tvalid = 1'b0;
    logic       up_tready;
    logic [7:0] down_data;
    logic       down_tlast, down_tuser, down_tvalid;
    logic       down_tready = 1'b1;
`ifdef VFS_STATS_EN
    logic [15:0] stat_frames, stat_short_lines, stat_long_lines, stat_short_frames, stat_dropped;
`endif

    video_frame_sanitizer #(
        .D_WIDTH(8), .H_ACTIVE(H), .V_ACTIVE(V), .PAD_VALUE(PAD)
    ) dut (
        .clk(clk), .rst(rst),
        .up_data(up_data), .up_tlast(up_tlast), .up_tuser(up_tuser),
        .up_tvalid(up_tvalid), .up_tready(up_tready),
        .down_data(down_data), .down_tlast(down_tlast), .down_tuser(down_tuser),
        .down_tvalid(down_tvalid), .down_tready(down_tready)
`ifdef VFS_STATS_EN
        , .stat_frames(stat_frames), .stat_short_lines(stat_short_lines),
        .stat_long_lines(stat_long_lines), .stat_short_frames(stat_short_frames),
        .stat_dropped(stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    // Beat encoding: [9] tuser, [8] tlast, [7:0] data
    logic [9:0] in_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         waits_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         rnd_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            down_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic       stall_prev = 1'b0;
    logic [10:0] prev_bundle = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 32'({down_tvalid, down_tuser, down_tlast, down_data}), 32'(prev_bundle));
            if (down_tvalid && down_tready)
                got_q.push_back({down_tuser, down_tlast, down_data});
            stall_prev  <= down_tvalid && !down_tready;
            prev_bundle <= {down_tvalid, down_tuser, down_tlast, down_data};
        end
    end

    // ---------------- reference model ----------------
    task automatic push_px(input logic [7:0] d, input int x, input int y);
        exp_q.push_back({(x == 0 && y == 0), (x == H - 1), d});
    endtask

    task automatic pad_line(input int x0, input int y);
        for (int x = x0; x < H; x++) push_px(PAD, x, y);
    endtask

    task automatic pad_frame(input int x0, input int y0);
        for (int y = y0; y < V; y++) pad_line((y == y0) ? x0 : 0, y);
    endtask

    task automatic model_run();
        int n, i, x, y;
        bit restart, stop, lt;
        n = in_q.size(); i = 0; restart = 0; stop = 0;
        exp_q.delete();
        while (!stop) begin
            if (!restart) begin
                while (i < n && !in_q[i][9]) i++;
                if (i >= n) break;
            end
            restart = 0;
            y = 0;
            while (y < V && !stop && !restart) begin
                x = 0; lt = 0;
                while (x < H && !lt) begin
                    if (i >= n) begin stop = 1; break; end
                    if (in_q[i][9] && (x != 0 || y != 0)) begin restart = 1; break; end
                    push_px(in_q[i][7:0], x, y);
                    lt = in_q[i][8];
                    x++; i++;
                end
                if (stop) break;
                if (restart) begin pad_frame(x, y); break; end
                if (x < H) begin
                    pad_line(x, y);
                end else if (!lt && y < V - 1) begin
                    while (i < n && !in_q[i][9] && !in_q[i][8]) i++;
                    if (i >= n) begin stop = 1; break; end
                    if (in_q[i][9]) begin restart = 1; pad_frame(0, y + 1); break; end
                    i++;
                end
                y++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic add(input logic [7:0] d, input bit tl, input bit tu);
        in_q.push_back({tu, tl, d});
    endtask

    task automatic add_frame(input logic [7:0] base, input bit rnd);
        for (int k = 0; k < H * V; k++)
            add(rnd ? 8'($urandom) : base + 8'(k), (k % H) == H - 1, k == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        in_q.delete();
        waits_q.delete();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [9:0] b, output int waits);
        int w;
        w = 0;
        up_tuser = b[9]; up_tlast = b[8]; up_data = b[7:0]; up_tvalid = 1'b1;
        @(negedge clk);
        while (!up_tready && w < 200) begin w++; @(negedge clk); end
        if (w >= 200) check("accept_timeout", 32'(up_tready), 32'd1);
        @(posedge clk);
        #1;
        up_tvalid = 1'b0;
        waits = w;
    endtask

    task automatic send_all(input bit gaps);
        int w;
        for (int k = 0; k < in_q.size(); k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_beat(in_q[k], w);
            waits_q.push_back(w);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 5000) begin @(posedge clk); t++; end
        repeat (12) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        do_reset();

        // Reset state
        check("rst_tvalid", 32'(down_tvalid), 32'd0);
        check("rst_tlast",  32'(down_tlast),  32'd0);
        check("rst_tuser",  32'(down_tuser),  32'd0);
        check("rst_data",   32'(down_data),   32'd0);
        check("rst_wait_sof_ready", 32'(up_tready), 32'd1);

        // 1: clean frame, latency of one clock after accept
        add_frame(8'd1, 0);
        model_run();
        send_beat(in_q[0], w);
        check("t1_sof_held_one_clk", 32'(w), 32'd1);
        check("t1_lat_tvalid", 32'(down_tvalid), 32'd1);
        check("t1_lat_tuser",  32'(down_tuser),  32'd1);
        check("t1_lat_data",   32'(down_data),   32'd1);
        for (int k = 1; k < in_q.size(); k++) send_beat(in_q[k], w);
        drain("t1");
        check("t1_eol", 32'(got_q[3]), 32'h104);

        // 2: leading junk is discarded
        do_reset();
        add(8'd9, 0, 0); add(8'd9, 0, 0);
        add_frame(8'd1, 0);
        model_run();
        send_all(0);
        drain("t2");
        check("t2_first", 32'(got_q[0]), 32'h201);
`ifdef VFS_STATS_EN
        check("t2_stat_dropped", 32'(stat_dropped), 32'd2);
        check("t2_stat_frames",  32'(stat_frames),  32'd1);
`endif

        // 3: short line padded
        do_reset();
        add(8'd1, 0, 1); add(8'd2, 1, 0);
        add(8'd5, 0, 0); add(8'd6, 0, 0); add(8'd7, 0, 0); add(8'd8, 1, 0);
        model_run();
        send_all(0);
        drain("t3");
        check("t3_ready_low_clks", 32'(waits_q[2]), 32'd2);
        check("t3_pad_mid",  32'(got_q[2]), 32'h0EE);
        check("t3_pad_last", 32'(got_q[3]), 32'h1EE);

        // 4: long line truncated
        do_reset();
        for (int k = 1; k <= 6; k++) add(8'(k), k == 6, k == 1);
        for (int k = 7; k <= 10; k++) add(8'(k), k == 10, 0);
        model_run();
        send_all(0);
        drain("t4");
        check("t4_trunc_eol", 32'(got_q[3]), 32'h104);
        check("t4_line2",     32'(got_q[4]), 32'h007);

        // 5: premature SOF pads the frame, held beat starts the next one
        do_reset();
        for (int k = 1; k <= 5; k++) add(8'(k), k == 4, k == 1);
        for (int k = 7; k <= 14; k++) add(8'(k), (k == 10) || (k == 14), k == 7);
        model_run();
        send_all(0);
        drain("t5");
        check("t5_pad_eol",  32'(got_q[7]), 32'h1EE);
        check("t5_new_sof",  32'(got_q[8]), 32'h207);

        // SOF with EOL on first pixel; long last line; recovery
        do_reset();
        add(8'd1, 1, 1);
        for (int k = 5; k <= 8; k++) add(8'(k), k == 8, 0);
        for (int k = 11; k <= 14; k++) add(8'(k), k == 14, k == 11);
        for (int k = 15; k <= 20; k++) add(8'(k), k == 20, 0);
        add_frame(8'd21, 0);
        model_run();
        send_all(0);
        drain("t_edge");
        check("t_edge_sof_eol", 32'(got_q[0]), 32'h201);
        check("t_edge_pad_eol", 32'(got_q[3]), 32'h1EE);
        check("t_edge_last_eol", 32'(got_q[15]), 32'h112);

        // Reset mid-frame aborts it
        do_reset();
        add_frame(8'd40, 0);
        for (int k = 0; k < 3; k++) send_beat(in_q[k], w);
        do_reset();
        check("mid_rst_tvalid", 32'(down_tvalid), 32'd0);
        check("mid_rst_data",   32'(down_data),   32'd0);
        check("mid_rst_ready",  32'(up_tready),   32'd1);
        add_frame(8'd60, 0);
        model_run();
        send_all(0);
        drain("mid_rst");

        // 6: random backpressure over 100 clean frames
        do_reset();
        rnd_rdy = 1'b1;
        for (int f = 0; f < 100; f++) add_frame(8'd0, 1);
        model_run();
        send_all(1);
        drain("t6");

        // Malformed random stream under backpressure
        do_reset();
        for (int k = 0; k < 400; k++)
            add(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        model_run();
        send_all(1);
        drain("t_rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
